// File: rtl/out_sample_player_pkg.sv
// Shared definitions for the fifo5 output sample player.
// Holds the FSM state encoding and the sample, fifo word and fill-level widths
// used by out_sample_player and out_sat_shift.
package out_sample_player_pkg;

  localparam int unsigned SAMPLE_W = 16;  // DAC sample width
  localparam int unsigned WORD_W   = 32;  // fifo5 word {re, im}
  localparam int unsigned USEDW_W  = 6;   // fifo5 usedw width

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_WAITQ    = 2'd2,
    ST_PLAY     = 2'd3
  } state_e;

endpackage

// File: rtl/out_sat_shift.sv
// Combinational gain-undo stage: arithmetic right shift of a signed 16-bit
// sample followed by saturation back to 16 bits.
// Ports:
//   din_i  - signed input sample (real half of the fifo5 word)
//   dout_o - shifted, saturated signed output sample
module out_sat_shift
  import out_sample_player_pkg::*;
#(
  parameter int unsigned SHIFT = 8
) (
  input  logic [SAMPLE_W-1:0] din_i,
  output logic [SAMPLE_W-1:0] dout_o
);

  logic signed [31:0] wide;

  // Work in 32 bits so the clamp stays meaningful for any SHIFT; with
  // SHIFT>=1 the result always fits and the clamp never fires.
  always_comb begin
    wide = {{(32 - SAMPLE_W){din_i[SAMPLE_W-1]}}, din_i};
    wide = wide >>> SHIFT;
    if (wide > 32'sd32767) begin
      dout_o = 16'h7FFF;
    end else if (wide < -32'sd32768) begin
      dout_o = 16'h8000;
    end else begin
      dout_o = wide[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/out_sample_player.sv
// Hardware player draining the overlap-added output FIFO (fifo5) toward the DAC.
// Prefills fifo5, keeps one word buffered ahead, and emits one scaled sample
// per sample_tick; detects and counts underruns.
// Ports:
//   clock, reset        - rising-edge clock, async active-low reset
//   enable              - level; low returns to IDLE and discards the buffered word
//   sample_tick         - one-cycle strobe at the audio rate (>=3 clocks apart)
//   empty5, usedw5      - fifo5 status
//   outFIFO5            - fifo5 q {re, im}, valid the cycle after rdreq5
//   rdreq5              - fifo5 read request
//   dac_data, dac_valid - output sample and its one-cycle strobe
//   playing             - high while in PLAY
//   underrun            - one-cycle pulse per underrun event
//   underrun_cnt        - saturating underrun event counter
module out_sample_player
  import out_sample_player_pkg::*;
#(
  parameter int unsigned PREFILL = 16,
  parameter int unsigned SHIFT   = 8,
  parameter int unsigned UCNT_W  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                sample_tick,
  input  logic                empty5,
  input  logic [USEDW_W-1:0]  usedw5,
  input  logic [WORD_W-1:0]   outFIFO5,
  output logic                rdreq5,
  output logic [SAMPLE_W-1:0] dac_data,
  output logic                dac_valid,
  output logic                playing,
  output logic                underrun,
  output logic [UCNT_W-1:0]   underrun_cnt
);

  localparam logic [USEDW_W-1:0] PREFILL_LVL = USEDW_W'(PREFILL);

  state_e              state_q, state_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic                rd_pend_q, rd_pend_d;
  logic [SAMPLE_W-1:0] dac_data_q, dac_data_d;
  logic                dac_valid_q, dac_valid_d;
  logic                underrun_q, underrun_d;
  logic [UCNT_W-1:0]   ucnt_q, ucnt_d;
  logic                rdreq;

  logic                avail;
  logic [SAMPLE_W-1:0] play_re;
  logic [SAMPLE_W-1:0] scaled;
  logic                unused_im;

  // Imaginary half is not needed for time-domain playback.
  assign unused_im = ^outFIFO5[WORD_W-SAMPLE_W-1:0];

  // A word arriving from fifo5 this very cycle is as good as a buffered one,
  // so a tick landing on the capture cycle consumes it straight from the bus.
  assign avail   = hold_vld_q | rd_pend_q;
  assign play_re = hold_vld_q ? hold_q : outFIFO5[WORD_W-1:WORD_W-SAMPLE_W];

  out_sat_shift #(
    .SHIFT(SHIFT)
  ) u_sat_shift (
    .din_i (play_re),
    .dout_o(scaled)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    rd_pend_d   = 1'b0;
    dac_data_d  = dac_data_q;
    dac_valid_d = 1'b0;
    underrun_d  = 1'b0;
    ucnt_d      = ucnt_q;
    rdreq       = 1'b0;

    if (!enable) begin
      // Any read already issued completes in fifo5; its word is dropped here
      // along with the buffered one.
      state_d    = ST_IDLE;
      hold_d     = '0;
      hold_vld_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (usedw5 >= PREFILL_LVL) state_d = ST_PREFETCH;
        end
        ST_PREFETCH: begin
          if (!empty5) begin
            rdreq     = 1'b1;
            rd_pend_d = 1'b1;
            state_d   = ST_WAITQ;
          end
        end
        ST_WAITQ: begin
          hold_d     = outFIFO5[WORD_W-1:WORD_W-SAMPLE_W];
          hold_vld_d = 1'b1;
          state_d    = ST_PLAY;
        end
        ST_PLAY: begin
          if (rd_pend_q) begin
            hold_d     = outFIFO5[WORD_W-1:WORD_W-SAMPLE_W];
            hold_vld_d = 1'b1;
          end
          if (sample_tick) begin
            dac_valid_d = 1'b1;
            if (avail) begin
              dac_data_d = scaled;
              hold_vld_d = 1'b0;
              if (!empty5) begin
                rdreq     = 1'b1;
                rd_pend_d = 1'b1;
              end
            end else begin
              dac_data_d = '0;
              underrun_d = 1'b1;
              if (ucnt_q != '1) ucnt_d = ucnt_q + UCNT_W'(1);
              hold_vld_d = 1'b0;
              state_d    = ST_IDLE;
            end
          end else if (!avail && !empty5) begin
            rdreq     = 1'b1;
            rd_pend_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      rd_pend_q   <= rd_pend_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      underrun_q  <= underrun_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign rdreq5       = rdreq;
  assign dac_data     = dac_data_q;
  assign dac_valid    = dac_valid_q;
  assign playing      = (state_q == ST_PLAY);
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_out_sample_player.sv
// Bench for out_sample_player: two instances (SHIFT=8/UCNT_W=8 and
// SHIFT=0/UCNT_W=2) share the control inputs, each fed by its own fifo5 model.
// Expected samples come from a queue of pushed words played in order.
module tb_out_sample_player;

  logic clock = 1'b0;
  logic reset, enable, sample_tick;
  always #5 clock = ~clock;

  logic        empty0, empty1;
  logic [5:0]  usedw0, usedw1;
  logic [31:0] fq0, fq1;
  logic        rd0, rd1;
  logic [15:0] data0, data1;
  logic        valid0, valid1, play0, play1, ur0, ur1;
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;

  logic        wr;
  logic [31:0] wdata;

  out_sample_player #(.PREFILL(16), .SHIFT(8), .UCNT_W(8)) u_dut0 (
    .clock(clock), .reset(reset), .enable(enable), .sample_tick(sample_tick),
    .empty5(empty0), .usedw5(usedw0), .outFIFO5(fq0), .rdreq5(rd0),
    .dac_data(data0), .dac_valid(valid0), .playing(play0),
    .underrun(ur0), .underrun_cnt(cnt0));

  out_sample_player #(.PREFILL(16), .SHIFT(0), .UCNT_W(2)) u_dut1 (
    .clock(clock), .reset(reset), .enable(enable), .sample_tick(sample_tick),
    .empty5(empty1), .usedw5(usedw1), .outFIFO5(fq1), .rdreq5(rd1),
    .dac_data(data1), .dac_valid(valid1), .playing(play1),
    .underrun(ur1), .underrun_cnt(cnt1));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // fifo5 models (show-ahead off: q valid the cycle after rdreq, aclr on reset)
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int unsigned pops0 = 0;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      q0.delete(); q1.delete();
      empty0 <= 1'b1; empty1 <= 1'b1;
      usedw0 <= '0;   usedw1 <= '0;
      fq0 <= '0;      fq1 <= '0;
    end else begin
      if (rd0) begin
        check_eq("rd_on_empty0", {31'd0, empty0}, 32'd0);
        if (q0.size() != 0) fq0 <= q0.pop_front();
        pops0 <= pops0 + 1;
      end
      if (rd1) begin
        check_eq("rd_on_empty1", {31'd0, empty1}, 32'd0);
        if (q1.size() != 0) fq1 <= q1.pop_front();
      end
      if (wr) begin
        q0.push_back(wdata);
        q1.push_back(wdata);
      end
      empty0 <= (q0.size() == 0);
      empty1 <= (q1.size() == 0);
      usedw0 <= (q0.size() > 63) ? 6'd63 : 6'(q0.size());
      usedw1 <= (q1.size() > 63) ? 6'd63 : 6'(q1.size());
    end
  end

  int unsigned ur_pulses1 = 0;
  always @(negedge clock) if (ur1) ur_pulses1 <= ur_pulses1 + 1;

  // Reference model: words not yet played, in order, plus play/underrun state.
  logic [15:0] model_q[$];
  bit          mplay;
  int unsigned ur_cnt, ur_total;
  logic [15:0] last0, last1;
  logic [15:0] junk;

  function automatic logic [15:0] shr8(input logic [15:0] re);
    int v;
    v = (re >= 16'h8000) ? int'(re) - 65536 : int'(re);
    v = (v >= 0) ? v / 256 : -((-v + 255) / 256);
    return v[15:0];
  endfunction

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_word(input logic [15:0] re);
    wdata = {re, 16'($urandom())};
    wr = 1'b1;
    @(negedge clock);
    wr = 1'b0;
    model_q.push_back(re);
    if (!mplay && enable && model_q.size() >= 16) mplay = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_data0"}, data0, 0);   check_eq({tag, "_data1"}, data1, 0);
    check_eq({tag, "_valid0"}, valid0, 0); check_eq({tag, "_valid1"}, valid1, 0);
    check_eq({tag, "_play0"}, play0, 0);   check_eq({tag, "_play1"}, play1, 0);
    check_eq({tag, "_ur0"}, ur0, 0);       check_eq({tag, "_ur1"}, ur1, 0);
    check_eq({tag, "_rd0"}, rd0, 0);       check_eq({tag, "_rd1"}, rd1, 0);
    check_eq({tag, "_cnt0"}, cnt0, 0);     check_eq({tag, "_cnt1"}, cnt1, 0);
  endtask

  task automatic do_tick();
    logic [15:0] re, e0, e1;
    bit ev, eu;
    ev = 1'b0; eu = 1'b0; e0 = last0; e1 = last1;
    if (enable && mplay) begin
      ev = 1'b1;
      if (model_q.size() != 0) begin
        re = model_q.pop_front();
        e0 = shr8(re);
        e1 = re;
      end else begin
        eu = 1'b1; e0 = '0; e1 = '0;
        ur_cnt++; ur_total++;
        mplay = 1'b0;
      end
    end
    sample_tick = 1'b1;
    @(negedge clock);
    sample_tick = 1'b0;
    check_eq("tick_valid0", valid0, ev); check_eq("tick_valid1", valid1, ev);
    check_eq("tick_data0", data0, e0);   check_eq("tick_data1", data1, e1);
    check_eq("tick_ur0", ur0, eu);       check_eq("tick_ur1", ur1, eu);
    check_eq("tick_cnt0", cnt0, (ur_cnt > 255) ? 255 : ur_cnt);
    check_eq("tick_cnt1", cnt1, (ur_cnt > 3) ? 3 : ur_cnt);
    check_eq("tick_play0", play0, mplay);
    last0 = e0; last1 = e1;
  endtask

  task automatic drop_enable(input bit with_tick);
    if (mplay && model_q.size() != 0) junk = model_q.pop_front();
    mplay = 1'b0;
    enable = 1'b0;
    sample_tick = with_tick;
    @(negedge clock);
    sample_tick = 1'b0;
    check_eq("drop_valid0", valid0, 0);
    check_eq("drop_ur0", ur0, 0);
    check_eq("drop_data0", data0, last0);
    check_eq("drop_data1", data1, last1);
    check_eq("drop_play0", play0, 0);
    check_eq("drop_cnt0", cnt0, (ur_cnt > 255) ? 255 : ur_cnt);
  endtask

  task automatic raise_enable();
    enable = 1'b1;
    if (model_q.size() >= 16) mplay = 1'b1;
    idle(6);
  endtask

  initial begin
    int unsigned base;
    reset = 1'b0; enable = 1'b0; sample_tick = 1'b0; wr = 1'b0; wdata = '0;
    mplay = 1'b0; ur_cnt = 0; ur_total = 0; last0 = '0; last1 = '0;
    idle(3);
    check_quiet("rst");
    reset = 1'b1;
    idle(2);

    // Prefill with re = 0x0100*n, then drain and underrun on the 17th tick
    enable = 1'b1;
    base = pops0;
    for (int n = 1; n <= 16; n++) push_word(16'(n * 256));
    idle(6);
    check_eq("prefetch_reads", pops0 - base, 1);
    check_eq("prefill_play0", play0, 1);
    repeat (17) begin do_tick(); idle(7); end
    check_eq("first_ur_cnt0", cnt0, 1);

    // Below prefill: 15 words, nothing may happen for 200 clocks
    push_word(16'h8000); push_word(16'h7FFF); push_word(16'hFFFF); push_word(16'h0080);
    for (int k = 0; k < 11; k++) push_word(16'($urandom()));
    for (int i = 0; i < 200; i++) begin
      sample_tick = (i % 8 == 0);
      @(negedge clock);
      check_eq("below_rd0", rd0, 0);
      check_eq("below_valid0", valid0, 0);
    end
    sample_tick = 1'b0;
    push_word(16'($urandom()));
    idle(6);
    repeat (17) begin do_tick(); idle(5); end

    // Randomised rounds: ticks, pushes during play, enable drops
    for (int r = 0; r < 5; r++) begin
      int unsigned n;
      n = 16 + $urandom_range(0, 6);
      for (int k = 0; k < int'(n); k++) push_word(16'($urandom()));
      idle(6);
      for (int it = 0; it < 120 && mplay; it++) begin
        int unsigned a;
        a = $urandom_range(0, 99);
        if (a < 75) do_tick();
        else if (a < 90) push_word(16'($urandom()));
        else begin
          drop_enable(1'($urandom_range(0, 1)));
          raise_enable();
        end
        idle($urandom_range(4, 7));
      end
    end

    // Make sure the 2-bit counter has been driven well past saturation
    for (int g = 0; g < 10 && ur_cnt < 6; g++) begin
      if (!mplay) for (int k = 0; k < 16; k++) push_word(16'($urandom()));
      idle(6);
      for (int t = 0; t < 60 && mplay; t++) begin do_tick(); idle(3); end
    end
    check_eq("sat_cnt1", cnt1, 3);

    // Async reset in the middle of PLAY, between clock edges
    for (int k = 0; k < 20; k++) push_word(16'($urandom()));
    idle(6);
    repeat (3) begin do_tick(); idle(5); end
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_quiet("arst");
    model_q.delete(); mplay = 1'b0; ur_cnt = 0; last0 = '0; last1 = '0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) push_word(16'($urandom()));
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      check_eq("post_rst_rd0", rd0, 0);
    end
    for (int k = 0; k < 6; k++) push_word(16'($urandom()));
    idle(6);
    repeat (17) begin do_tick(); idle(4); end

    check_eq("ur_pulses1", ur_pulses1, ur_total);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
